// File: rtl/miner_ctrl_multi.sv
// miner_ctrl_multi: top-level sequencer for a multi-core SHA-256 miner.
// It counts the header words from the serial loader, runs the core array,
// picks one of several simultaneous solution claims round-robin, and drops
// back to idle once every core has exhausted its nonce range.
//
// Ports
//   clk, n_rst       system clock, synchronous active-low reset
//   start_found      host start-of-job marker
//   word_valid       one-cycle strobe per 32-bit loader word
//   abort            host abort, returns to IDLE from any state
//   sol_claim        per-core candidate-nonce level
//   core_done        per-core nonce-range exhausted
//   sol_response     host verdict: 00 wait, 01 reject, 1x accept/new job
//   state            current state encoding
//   shift_midstate   midstate shift enable (combinational)
//   shift_header     remaining-header shift enable (combinational)
//   core_enable      per-core run enable (combinational)
//   claim_core       index of the granted core (registered)
//   exhausted        one-cycle pulse when all cores are spent without a win
//
// state                 | meaning
// IDLE          (000)   | waiting for start_found, internal counters cleared
// LOAD_MIDSTATE (001)   | shifting MIDSTATE_WORDS words into the midstate reg
// LOAD_REM_HDR  (010)   | shifting HEADER_WORDS words into the header reg
// SOLVE         (011)   | live cores hashing, claims and done flags watched
// HALT          (100)   | cores paused while the host checks claim_core
// EXHAUSTED     (101)   | all cores spent, exhausted pulse, then IDLE
module miner_ctrl_multi #(
  parameter int NUM_CORES      = 4,
  parameter int MIDSTATE_WORDS = 8,
  parameter int HEADER_WORDS   = 3,
  parameter int CORE_W         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start_found,
  input  logic                 word_valid,
  input  logic                 abort,
  input  logic [NUM_CORES-1:0] sol_claim,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [1:0]           sol_response,
  output logic [2:0]           state,
  output logic                 shift_midstate,
  output logic                 shift_header,
  output logic [NUM_CORES-1:0] core_enable,
  output logic [CORE_W-1:0]    claim_core,
  output logic                 exhausted
);

  localparam int MAX_WORDS = (MIDSTATE_WORDS > HEADER_WORDS) ? MIDSTATE_WORDS : HEADER_WORDS;
  localparam int WCNT_W    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [WCNT_W-1:0] MID_LAST = WCNT_W'(MIDSTATE_WORDS - 1);
  localparam logic [WCNT_W-1:0] HDR_LAST = WCNT_W'(HEADER_WORDS - 1);
  localparam logic [CORE_W:0]   NC_EXT   = (CORE_W+1)'(NUM_CORES);

  typedef enum logic [2:0] {
    IDLE          = 3'b000,
    LOAD_MIDSTATE = 3'b001,
    LOAD_REM_HDR  = 3'b010,
    SOLVE         = 3'b011,
    HALT          = 3'b100,
    EXHAUSTED     = 3'b101
  } state_t;

  state_t                state_q, state_d;
  logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic [NUM_CORES-1:0]  done_mask_q, done_mask_d;
  logic [CORE_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CORE_W-1:0]     claim_core_q, claim_core_d;
  logic                  exhausted_q, exhausted_d;

  logic [NUM_CORES-1:0]  eligible;
  logic [NUM_CORES-1:0]  done_next;
  logic                  grant_vld;
  logic [CORE_W-1:0]     grant_idx;
  logic [CORE_W:0]       scan_sum;
  logic [CORE_W-1:0]     scan_idx;
  logic [CORE_W:0]       ptr_sum;
  logic [CORE_W-1:0]     ptr_inc;

  // Round-robin scan: offsets 0..N-1 from rr_ptr, wrapped modulo NUM_CORES
  // with one extra bit so non-power-of-two core counts wrap correctly.
  always_comb begin
    eligible  = sol_claim & ~done_mask_q;
    done_next = done_mask_q | core_done;
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (CORE_W+1)'(i);
      if (scan_sum >= NC_EXT) scan_sum = scan_sum - NC_EXT;
      scan_idx = scan_sum[CORE_W-1:0];
      if (!grant_vld && eligible[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
    ptr_sum = {1'b0, claim_core_q} + (CORE_W+1)'(1);
    if (ptr_sum >= NC_EXT) ptr_sum = '0;
    ptr_inc = ptr_sum[CORE_W-1:0];
  end

  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    done_mask_d    = done_mask_q;
    rr_ptr_d       = rr_ptr_q;
    claim_core_d   = claim_core_q;
    exhausted_d    = 1'b0;
    shift_midstate = 1'b0;
    shift_header   = 1'b0;
    core_enable    = '0;
    case (state_q)
      IDLE: begin
        word_cnt_d  = '0;
        done_mask_d = '0;
        rr_ptr_d    = '0;
        if (start_found) state_d = LOAD_MIDSTATE;
      end
      LOAD_MIDSTATE: begin
        shift_midstate = word_valid;
        if (word_valid) begin
          if (word_cnt_q == MID_LAST) begin
            state_d    = LOAD_REM_HDR;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      LOAD_REM_HDR: begin
        shift_header = word_valid;
        if (word_valid) begin
          if (word_cnt_q == HDR_LAST) begin
            state_d    = SOLVE;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      SOLVE: begin
        core_enable = ~done_mask_q;
        // done flags are captured even on the cycle that leaves for HALT
        done_mask_d = done_next;
        if (grant_vld) begin
          claim_core_d = grant_idx;
          state_d      = HALT;
        end else if (&done_next) begin
          state_d     = EXHAUSTED;
          exhausted_d = 1'b1;
        end
      end
      HALT: begin
        if (sol_response == 2'b01) begin
          state_d  = SOLVE;
          rr_ptr_d = ptr_inc;
        end else if (sol_response[1]) begin
          state_d = IDLE;
        end
      end
      EXHAUSTED: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // abort discards partial work; a grant in the same cycle is not taken
    if (abort) begin
      state_d      = IDLE;
      word_cnt_d   = '0;
      done_mask_d  = '0;
      rr_ptr_d     = '0;
      claim_core_d = claim_core_q;
      exhausted_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      done_mask_q  <= '0;
      rr_ptr_q     <= '0;
      claim_core_q <= '0;
      exhausted_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      done_mask_q  <= done_mask_d;
      rr_ptr_q     <= rr_ptr_d;
      claim_core_q <= claim_core_d;
      exhausted_q  <= exhausted_d;
    end
  end

  assign state      = state_q;
  assign claim_core = claim_core_q;
  assign exhausted  = exhausted_q;

endmodule

// File: tb/tb_miner_ctrl_multi.sv
module tb_miner_ctrl_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst, start_found, word_valid, abort;
  logic [15:0] sol_claim, core_done;
  logic [1:0]  sol_response;

  logic [2:0]  st4, st16, st1;
  logic        shm4, shh4, shm16, shh16, shm1, shh1;
  logic [3:0]  ce4;
  logic [15:0] ce16;
  logic [0:0]  ce1;
  logic [1:0]  cc4;
  logic [3:0]  cc16;
  logic [0:0]  cc1;
  logic        ex4, ex16, ex1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  miner_ctrl_multi #(.NUM_CORES(4), .MIDSTATE_WORDS(8), .HEADER_WORDS(3)) u4 (
    .clk(clk), .n_rst(n_rst), .start_found(start_found), .word_valid(word_valid),
    .abort(abort), .sol_claim(sol_claim[3:0]), .core_done(core_done[3:0]),
    .sol_response(sol_response), .state(st4), .shift_midstate(shm4),
    .shift_header(shh4), .core_enable(ce4), .claim_core(cc4), .exhausted(ex4));

  miner_ctrl_multi #(.NUM_CORES(16), .MIDSTATE_WORDS(1), .HEADER_WORDS(3)) u16 (
    .clk(clk), .n_rst(n_rst), .start_found(start_found), .word_valid(word_valid),
    .abort(abort), .sol_claim(sol_claim), .core_done(core_done),
    .sol_response(sol_response), .state(st16), .shift_midstate(shm16),
    .shift_header(shh16), .core_enable(ce16), .claim_core(cc16), .exhausted(ex16));

  miner_ctrl_multi #(.NUM_CORES(1), .MIDSTATE_WORDS(8), .HEADER_WORDS(3)) u1 (
    .clk(clk), .n_rst(n_rst), .start_found(start_found), .word_valid(word_valid),
    .abort(abort), .sol_claim(sol_claim[0:0]), .core_done(core_done[0:0]),
    .sol_response(sol_response), .state(st1), .shift_midstate(shm1),
    .shift_header(shh1), .core_enable(ce1), .claim_core(cc1), .exhausted(ex1));

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: job phase number (equal to the state encoding), words
  // loaded so far, set of spent cores, rotation start, last granted core.
  typedef struct {
    int        st;
    int        words;
    bit [15:0] spent;
    int        ptr;
    int        claim;
    bit        exh;
  } mst_t;

  mst_t m4, m16, m1;

  function automatic bit [15:0] full_mask(int nc);
    return (nc >= 16) ? 16'hFFFF : 16'((1 << nc) - 1);
  endfunction

  function automatic mst_t model_next(mst_t m, int nc, int mw, int hw);
    mst_t      n;
    bit [15:0] full, live, tmp;
    int        idx;
    full  = full_mask(nc);
    n     = m;
    n.exh = 1'b0;
    if (!n_rst) begin
      n.st = 0; n.words = 0; n.spent = '0; n.ptr = 0; n.claim = 0;
      return n;
    end
    if (abort) begin
      n.st = 0; n.words = 0; n.spent = '0; n.ptr = 0;
      return n;
    end
    case (m.st)
      0: begin
        n.words = 0; n.spent = '0; n.ptr = 0;
        if (start_found) n.st = 1;
      end
      1, 2: if (word_valid) begin
        n.words = m.words + 1;
        if (n.words == ((m.st == 1) ? mw : hw)) begin
          n.st = m.st + 1; n.words = 0;
        end
      end
      3: begin
        n.spent = m.spent | (core_done & full);
        live    = sol_claim & ~m.spent & full;
        if (live != 0) begin
          for (int k = 0; k < nc; k++) begin
            idx = (m.ptr + k) % nc;
            tmp = live >> idx;
            if (tmp[0]) begin n.claim = idx; break; end
          end
          n.st = 4;
        end else if (n.spent == full) begin
          n.st = 5; n.exh = 1'b1;
        end
      end
      4: begin
        if (sol_response == 2'b01) begin
          n.st = 3; n.ptr = (m.claim + 1) % nc;
        end else if (sol_response[1]) n.st = 0;
      end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    m4  <= model_next(m4, 4, 8, 3);
    m16 <= model_next(m16, 16, 1, 3);
    m1  <= model_next(m1, 1, 8, 3);
  end

  task automatic cmp_dut(string tag, int nc, mst_t m, int st, int shm, int shh,
                         int ce, int cc, int ex);
    bit [15:0] full;
    full = full_mask(nc);
    chk({tag, ".state"}, st, m.st);
    chk({tag, ".shift_midstate"}, shm, int'(m.st == 1 && word_valid));
    chk({tag, ".shift_header"}, shh, int'(m.st == 2 && word_valid));
    chk({tag, ".core_enable"}, ce, (m.st == 3) ? int'(~m.spent & full) : 0);
    chk({tag, ".claim_core"}, cc, m.claim);
    chk({tag, ".exhausted"}, ex, int'(m.exh));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("m_u4", 4, m4, int'(st4), int'(shm4), int'(shh4), int'(ce4), int'(cc4), int'(ex4));
      cmp_dut("m_u16", 16, m16, int'(st16), int'(shm16), int'(shh16), int'(ce16), int'(cc16), int'(ex16));
      cmp_dut("m_u1", 1, m1, int'(st1), int'(shm1), int'(shh1), int'(ce1), int'(cc1), int'(ex1));
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Check u4 in the current cycle, then move on to the next cycle.
  task automatic expect_u4(string tag, int st, int ce, int cc, int ex);
    @(negedge clk);
    chk({tag, ".state"}, int'(st4), st);
    chk({tag, ".core_enable"}, int'(ce4), ce);
    if (cc >= 0) chk({tag, ".claim_core"}, int'(cc4), cc);
    chk({tag, ".exhausted"}, int'(ex4), ex);
    step();
  endtask

  task automatic run_load(string tag);
    int nm, nh;
    nm = 0; nh = 0;
    start_found = 1'b1; step(); start_found = 1'b0;
    for (int w = 0; w < 11; w++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        if (shm4) nm++;
        if (shh4) nh++;
        step();
      end
      word_valid = 1'b1;
      @(negedge clk);
      if (shm4) nm++;
      if (shh4) nh++;
      step();
      word_valid = 1'b0;
    end
    expect_u4({tag, ".solve"}, 3, 4'hF, -1, 0);
    chk({tag, ".midstate_pulses"}, nm, 8);
    chk({tag, ".header_pulses"}, nh, 3);
  endtask

  typedef struct {
    bit        sf;
    bit        wv;
    bit [3:0]  sc;
    bit [1:0]  rsp;
    int        st;
    bit        shm;
    bit        shh;
    bit [3:0]  ce;
    int        cc;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t v(bit sf, bit wv, bit [3:0] sc, bit [1:0] rsp, int st,
                             bit shm, bit shh, bit [3:0] ce, int cc);
    vec_t r;
    r.sf = sf; r.wv = wv; r.sc = sc; r.rsp = rsp; r.st = st;
    r.shm = shm; r.shh = shh; r.ce = ce; r.cc = cc;
    return r;
  endfunction

  initial begin
    int r;
    tbl[0]  = v(1, 0, 4'h0, 2'd0, 0, 0, 0, 4'h0, 0);
    tbl[1]  = v(0, 1, 4'h0, 2'd0, 1, 1, 0, 4'h0, 0);
    tbl[2]  = v(0, 1, 4'h0, 2'd0, 1, 1, 0, 4'h0, 0);
    tbl[3]  = v(0, 1, 4'h0, 2'd0, 1, 1, 0, 4'h0, 0);
    tbl[4]  = v(0, 0, 4'h0, 2'd0, 1, 0, 0, 4'h0, 0);
    tbl[5]  = v(0, 1, 4'h0, 2'd0, 1, 1, 0, 4'h0, 0);
    tbl[6]  = v(0, 1, 4'h0, 2'd0, 1, 1, 0, 4'h0, 0);
    tbl[7]  = v(0, 1, 4'h0, 2'd0, 1, 1, 0, 4'h0, 0);
    tbl[8]  = v(0, 1, 4'h0, 2'd0, 1, 1, 0, 4'h0, 0);
    tbl[9]  = v(0, 1, 4'h0, 2'd0, 1, 1, 0, 4'h0, 0);
    tbl[10] = v(0, 1, 4'h0, 2'd0, 2, 0, 1, 4'h0, 0);
    tbl[11] = v(0, 1, 4'h0, 2'd0, 2, 0, 1, 4'h0, 0);
    tbl[12] = v(0, 1, 4'h0, 2'd0, 2, 0, 1, 4'h0, 0);
    tbl[13] = v(0, 0, 4'h0, 2'd0, 3, 0, 0, 4'hF, 0);
    tbl[14] = v(0, 0, 4'hA, 2'd0, 3, 0, 0, 4'hF, 0);
    tbl[15] = v(0, 0, 4'hA, 2'd0, 4, 0, 0, 4'h0, 1);
    tbl[16] = v(0, 0, 4'hA, 2'd1, 4, 0, 0, 4'h0, 1);
    tbl[17] = v(0, 0, 4'hA, 2'd0, 3, 0, 0, 4'hF, 1);
    tbl[18] = v(0, 0, 4'hA, 2'd1, 4, 0, 0, 4'h0, 3);
    tbl[19] = v(0, 0, 4'hA, 2'd0, 3, 0, 0, 4'hF, 3);
    tbl[20] = v(0, 0, 4'h0, 2'd2, 4, 0, 0, 4'h0, 1);
    tbl[21] = v(0, 0, 4'h0, 2'd0, 0, 0, 0, 4'h0, 1);

    n_rst = 1'b0; start_found = 1'b0; word_valid = 1'b0; abort = 1'b0;
    sol_claim = '0; core_done = '0; sol_response = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    chk_en = 1'b1;

    @(negedge clk);
    chk("reset.state", int'(st4), 0);
    chk("reset.claim_core", int'(cc4), 0);
    chk("reset.core_enable", int'(ce4), 0);
    chk("reset.exhausted", int'(ex4), 0);
    chk("reset.shift_midstate", int'(shm4), 0);
    step();

    for (int i = 0; i < 22; i++) begin
      start_found  = tbl[i].sf;
      word_valid   = tbl[i].wv;
      sol_claim    = {12'h000, tbl[i].sc};
      sol_response = tbl[i].rsp;
      @(negedge clk);
      chk($sformatf("tbl%0d.state", i), int'(st4), tbl[i].st);
      chk($sformatf("tbl%0d.shift_midstate", i), int'(shm4), int'(tbl[i].shm));
      chk($sformatf("tbl%0d.shift_header", i), int'(shh4), int'(tbl[i].shh));
      chk($sformatf("tbl%0d.core_enable", i), int'(ce4), int'(tbl[i].ce));
      chk($sformatf("tbl%0d.claim_core", i), int'(cc4), tbl[i].cc);
      step();
    end
    start_found = 1'b0; word_valid = 1'b0; sol_claim = '0; sol_response = 2'd0;

    // Done-core claims ignored, done captured on the grant cycle, long HALT,
    // then reset in the middle of SOLVE.
    run_load("jobA");
    core_done = 16'h0001; step(); core_done = '0;
    expect_u4("jobA.done0", 3, 4'hE, -1, 0);
    sol_claim = 16'h0001; step(); sol_claim = '0;
    expect_u4("jobA.spent_claim", 3, 4'hE, -1, 0);
    sol_claim = 16'h0004; core_done = 16'h0002; step();
    sol_claim = '0; core_done = '0;
    expect_u4("jobA.grant2", 4, 4'h0, 2, 0);
    for (int i = 0; i < 50; i++) expect_u4("jobA.hold", 4, 4'h0, 2, 0);
    sol_response = 2'd1; step(); sol_response = 2'd0;
    expect_u4("jobA.reject", 3, 4'hC, 2, 0);
    n_rst = 1'b0; word_valid = 1'b1; step();
    @(negedge clk);
    chk("rst_mid.state", int'(st4), 0);
    chk("rst_mid.claim_core", int'(cc4), 0);
    chk("rst_mid.core_enable", int'(ce4), 0);
    chk("rst_mid.exhausted", int'(ex4), 0);
    chk("rst_mid.shift_midstate", int'(shm4), 0);
    chk("rst_mid.shift_header", int'(shh4), 0);
    step();
    n_rst = 1'b1; word_valid = 1'b0;

    // Cores finish one at a time in order 0, 2, 1, 3.
    run_load("jobB");
    core_done = 16'h0001; step(); core_done = '0;
    expect_u4("jobB.done0", 3, 4'hE, -1, 0);
    core_done = 16'h0004; step(); core_done = '0;
    expect_u4("jobB.done2", 3, 4'hA, -1, 0);
    core_done = 16'h0002; step(); core_done = '0;
    expect_u4("jobB.done1", 3, 4'h8, -1, 0);
    core_done = 16'h0008; step(); core_done = '0;
    expect_u4("jobB.exhausted", 5, 4'h0, -1, 1);
    expect_u4("jobB.idle", 0, 4'h0, -1, 0);

    // The last core finishes and claims in the same cycle: the claim wins.
    run_load("jobC");
    core_done = 16'h0007; step(); core_done = '0;
    expect_u4("jobC.done012", 3, 4'h8, -1, 0);
    core_done = 16'h0008; sol_claim = 16'h0008; step();
    core_done = '0; sol_claim = '0;
    expect_u4("jobC.grant3", 4, 4'h0, 3, 0);
    expect_u4("jobC.no_exh", 4, 4'h0, 3, 0);
    sol_response = 2'd2; step(); sol_response = 2'd0;
    expect_u4("jobC.accept", 0, 4'h0, 3, 0);

    // Abort after five midstate words; the next job needs the full load.
    start_found = 1'b1; step(); start_found = 1'b0;
    word_valid = 1'b1;
    repeat (5) step();
    word_valid = 1'b0;
    abort = 1'b1; step(); abort = 1'b0;
    expect_u4("abort.idle", 0, 4'h0, -1, 0);
    run_load("jobD");
    sol_response = 2'd3; sol_claim = 16'h0002; step();
    sol_claim = '0; sol_response = 2'd0;
    expect_u4("jobD.grant1", 4, 4'h0, 1, 0);
    sol_response = 2'd3; step(); sol_response = 2'd0;
    expect_u4("jobD.newjob", 0, 4'h0, 1, 0);

    // Random traffic; the reference model checks every DUT every cycle.
    for (int c = 0; c < 4000; c++) begin
      n_rst       = ($urandom_range(0, 499) != 0);
      start_found = ($urandom_range(0, 7) == 0);
      word_valid  = 1'($urandom_range(0, 1));
      abort       = ($urandom_range(0, 99) == 0);
      sol_claim   = 16'($urandom & $urandom & $urandom);
      core_done   = 16'($urandom & $urandom & $urandom & $urandom);
      r = $urandom_range(0, 9);
      sol_response = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : 2'($urandom_range(2, 3));
      step();
    end

    n_rst = 1'b1; start_found = 1'b0; word_valid = 1'b0; abort = 1'b0;
    sol_claim = '0; core_done = '0; sol_response = 2'd0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/miner_ctrl_multi.md
# miner_ctrl_multi

Top-level mining controller for a multi-core build. It sequences header loading and solution hand-off across `NUM_CORES` parallel SHA-256 cores. Loaded words are counted internally, replacing the external shift-done strobes. Simultaneous solution claims are arbitrated round-robin. Per-core nonce-range exhaustion is tracked, and the controller returns to idle once every core is spent. It sits between the host serial loader and the core array.

## Interface
Parameters:
- `NUM_CORES`, 4, number of hashing cores (1..16)
- `MIDSTATE_WORDS`, 8, 32-bit words in the midstate load
- `HEADER_WORDS`, 3, 32-bit words in the remaining-header load
- `CORE_W`, `$clog2(NUM_CORES)` (1 if `NUM_CORES`=1), width of the core index

Ports:
- `clk`  in  1  system clock; everything is on the rising edge
- `n_rst`  in  1  reset; one clock, reset is synchronous and active-low
- `start_found`  in  1  host start-of-job marker detected
- `word_valid`  in  1  one-cycle strobe: loader presents one 32-bit word
- `abort`  in  1  host abort of the current job
- `sol_claim`  in  `NUM_CORES`  per-core level: core holds a candidate nonce
- `core_done`  in  `NUM_CORES`  per-core pulse or level: nonce range exhausted
- `sol_response`  in  2  host verdict on the claimed solution
- `state`  out  3  current state encoding
- `shift_midstate`  out  1  shift enable into the midstate register
- `shift_header`  out  1  shift enable into the header register
- `core_enable`  out  `NUM_CORES`  per-core run enable
- `claim_core`  out  `CORE_W`  index of the core whose claim is being serviced
- `exhausted`  out  1  one-cycle pulse: all cores spent, no solution

## Operation
States and encodings: IDLE=000, LOAD_MIDSTATE=001, LOAD_REMAINING_HEADER=010, SOLVE=011, HALT=100, EXHAUSTED=101. Encodings 110 and 111 go to IDLE on the next cycle.

State transitions, in priority order (`n_rst` low overrides all, then `abort` sends any state to IDLE):
- IDLE: on `start_found` go to LOAD_MIDSTATE. Clear `word_cnt`, `done_mask` and `rr_ptr`.
- LOAD_MIDSTATE:
  - `shift_midstate = word_valid`; each strobe increments `word_cnt`.
  - On the strobe that arrives with `word_cnt == MIDSTATE_WORDS-1`, go to LOAD_REMAINING_HEADER and reset `word_cnt` to 0.
- LOAD_REMAINING_HEADER: same scheme with `shift_header` and `HEADER_WORDS`, then go to SOLVE.
- SOLVE:
  - `core_enable = ~done_mask`.
  - `done_mask |= core_done` every cycle.
  - Eligible claims are `sol_claim & ~done_mask`.
  - If any claim is eligible, grant the first one at or after `rr_ptr`, scanning upward modulo `NUM_CORES`. Register its index into `claim_core` and go to HALT.
  - Otherwise, if `(done_mask | core_done)` is all ones, go to EXHAUSTED.
  - A claim wins over exhaustion in the same cycle.
- HALT:
  - `core_enable` is all zeros.
  - `sol_response`=00: stay in HALT.
  - `sol_response`=01 (rejected): return to SOLVE, set `rr_ptr = claim_core+1` (modulo `NUM_CORES`), and keep `done_mask`.
  - `sol_response`=10 or 11 (accepted/new job): go to IDLE.
- EXHAUSTED: `exhausted`=1 for exactly one cycle, then go to IDLE.

Other output rules:
- `claim_core` holds its value outside of grants.
- `shift_*` are zero outside their load states.
- `core_enable` is zero outside SOLVE.

## Timing
- Reset values: `state`=000, `claim_core`=0, `exhausted`=0, `core_enable`=0, `shift_*`=0. Internal `word_cnt`, `done_mask` and `rr_ptr` reset to 0.
- `state`, `claim_core`, `exhausted`, `word_cnt`, `done_mask` and `rr_ptr` are registered.
- `shift_*` and `core_enable` are combinational from the state register and inputs, with zero added latency.
- Load phase: exactly `MIDSTATE_WORDS` shift pulses, then exactly `HEADER_WORDS` shift pulses. The first word may arrive in the cycle right after `start_found`. Gaps between strobes are unbounded.
- SOLVE to HALT: `claim_core` is valid in the first HALT cycle, and `core_enable` drops in that same cycle.
- `core_done` asserted in the cycle of the SOLVE to HALT transition is still recorded into `done_mask`.
- `abort` during a load discards partial counts. The next job starts from `word_cnt`=0.
- `sol_claim` from a core already in `done_mask` is ignored.

## Test plan
- Normal job, `NUM_CORES`=4:
  - Stimulus: `start_found`, then 8 strobes, then 3 strobes spaced by random gaps.
  - Required: exactly 8 `shift_midstate` pulses, then 3 `shift_header` pulses; `state` reaches 011 one cycle after the 11th strobe; `core_enable`=1111.
- Simultaneous claims:
  - Stimulus: `sol_claim`=1010 with `rr_ptr`=0, giving `claim_core`=1. Respond 01. Hold the claims.
  - Required: next grant has `claim_core`=3. Respond 01 again: next grant has `claim_core`=1 (wrap-around).
- Accept:
  - Stimulus: `sol_response`=10 in HALT.
  - Required: IDLE next cycle, `core_enable`=0.
  - Stimulus: hold `sol_response`=00 for 50 cycles.
  - Required: stays in HALT, `claim_core` stable.
- Exhaustion:
  - Stimulus: `core_done` pulses on cores 0, 2, 1, 3 on separate cycles.
  - Required: `core_enable` bits drop one by one; `exhausted` pulses one cycle after the last pulse, then IDLE.
  - Stimulus: core 3 done and core 3 claims in the same cycle.
  - Required: HALT with `claim_core`=3, no `exhausted`.
- Abort and reset:
  - Stimulus: `abort` after 5 midstate words, then a fresh job.
  - Required: the fresh job needs a full 8+3 words.
  - Stimulus: `n_rst` low mid-SOLVE.
  - Required: all outputs at reset values on the next edge.
- Parameter sweep: `NUM_CORES`=1 and 16, `MIDSTATE_WORDS`=1 with all of the above checks.
